// File: rtl/dfm_pkg.sv
// Shared types for the reciprocal frequency-measurement core.
package dfm_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEASURE,
        WAIT_EDGE,
        DONE
    } dfm_state_t;

    // Packed so that sig_cnt lands in the upper half of the 64-bit result word.
    typedef struct packed {
        logic [CNT_W-1:0] sig_cnt;
        logic [CNT_W-1:0] ref_cnt;
    } dfm_result_t;

endpackage

// File: rtl/dfm_sync_edge.sv
// Multi-flop synchroniser for an asynchronous signal followed by a rising-edge detector.
module dfm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sig_i,
    output logic sig_rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/dfm_core.sv
// Reciprocal frequency counter: gates on signal edges, counts reference cycles and
// signal periods, and emits {sig_cnt, ref_cnt} with a one-cycle write strobe.
module dfm_core
    import dfm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               sig_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   gate_len_i,
    output logic               busy_o,
    output logic               timeout_o,
    output logic               overflow_o,
    output logic               reg_wr_en_o,
    output logic [2*CNT_W-1:0] reg_wr_data_o
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYCLES);

    dfm_state_t        state_q, state_d;
    logic [CNT_W-1:0]  gate_q, gate_d;
    logic [CNT_W-1:0]  ref_q, ref_d;
    logic [CNT_W-1:0]  sig_q, sig_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;
    logic              ovf_q, ovf_d;
    logic              wr_en_q, wr_en_d;
    dfm_result_t       wr_data_q, wr_data_d;

    logic              sig_rise;
    logic [CNT_W-1:0]  ref_inc, sig_inc;
    logic [IDLE_W-1:0] idle_inc;

    dfm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .sig_i      (sig_i),
        .sig_rise_o (sig_rise)
    );

    // Saturating increments; idle_cnt never passes the limit since it aborts there.
    assign ref_inc  = (ref_q == '1) ? ref_q : ref_q + 1'b1;
    assign sig_inc  = (sig_q == '1) ? sig_q : sig_q + 1'b1;
    assign idle_inc = idle_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        ref_d     = ref_q;
        sig_d     = sig_q;
        idle_d    = idle_q;
        timeout_d = timeout_q;
        ovf_d     = ovf_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    gate_d    = (gate_len_i == '0) ? CNT_W'(1) : gate_len_i;
                    timeout_d = 1'b0;
                    ovf_d     = 1'b0;
                    idle_d    = '0;
                    state_d   = ARM;
                end
            end
            ARM: begin
                if (sig_rise) begin
                    ref_d   = '0;
                    sig_d   = '0;
                    idle_d  = '0;
                    state_d = MEASURE;
                end else begin
                    idle_d = idle_inc;
                    if (idle_inc == IDLE_LIM) begin
                        timeout_d = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_data_d = '0;
                        state_d   = DONE;
                    end
                end
            end
            MEASURE, WAIT_EDGE: begin
                ref_d = ref_inc;
                if (ref_inc == '1) ovf_d = 1'b1;
                if (sig_rise) begin
                    sig_d  = sig_inc;
                    idle_d = '0;
                    if (sig_inc == '1) ovf_d = 1'b1;
                end else begin
                    idle_d = idle_inc;
                end

                // Gate closes only on a signal edge once the minimum time has elapsed.
                if (!sig_rise && idle_inc == IDLE_LIM) begin
                    timeout_d = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_data_d = '0;
                    state_d   = DONE;
                end else if (sig_rise && (state_q == WAIT_EDGE || ref_inc >= gate_q)) begin
                    wr_en_d           = 1'b1;
                    wr_data_d.sig_cnt = sig_inc;
                    wr_data_d.ref_cnt = ref_inc;
                    state_d           = DONE;
                end else if (state_q == MEASURE && ref_inc >= gate_q) begin
                    state_d = WAIT_EDGE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            gate_q    <= '0;
            ref_q     <= '0;
            sig_q     <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            gate_q    <= gate_d;
            ref_q     <= ref_d;
            sig_q     <= sig_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy_o        = (state_q == ARM) || (state_q == MEASURE) || (state_q == WAIT_EDGE);
    assign timeout_o     = timeout_q;
    assign overflow_o    = ovf_q;
    assign reg_wr_en_o   = wr_en_q;
    assign reg_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_dfm_core.sv
// Directed and randomised checks of dfm_core against a period-list reference model.
module tb_dfm_core;
    import dfm_pkg::*;

    localparam int TO = 1000;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sig = 1'b0;
    logic               start = 1'b0;
    logic [CNT_W-1:0]   gate_len = '0;
    logic               busy, timeout, overflow, wr_en;
    logic [2*CNT_W-1:0] wr_data;

    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    logic [63:0] wr_last = '0;
    int          per_q[$];

    always #5 clk = ~clk;

    dfm_core #(
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES   (2)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .sig_i         (sig),
        .start_i       (start),
        .gate_len_i    (gate_len),
        .busy_o        (busy),
        .timeout_o     (timeout),
        .overflow_o    (overflow),
        .reg_wr_en_o   (wr_en),
        .reg_wr_data_o (wr_data)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            wr_last <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: the gate closes on the first edge whose distance from the opening edge
    // reaches max(gate,1); ref = that distance, sig = periods covered.
    task automatic build(input int g, input int pmin, input int pmax,
                         output int eref, output int esig);
        int tgt;
        int p;
        tgt  = (g == 0) ? 1 : g;
        eref = 0;
        esig = 0;
        per_q.delete();
        while (eref < tgt) begin
            p = $urandom_range(pmax, pmin);
            per_q.push_back(p);
            eref += p;
            esig++;
        end
    endtask

    task automatic do_start(input int g);
        gate_len = CNT_W'(g);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Opening rise, then one rise at the end of each listed period.
    task automatic run_wave(input int start_at);
        int cyc;
        cyc = 0;
        sig = 1'b1;
        foreach (per_q[k]) begin
            for (int c = 0; c < per_q[k]; c++) begin
                if (c == per_q[k] / 2) sig = 1'b0;
                start = (cyc == start_at);
                @(negedge clk);
                cyc++;
            end
            sig = 1'b1;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        sig = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic measure(input string tag, input int g, input int pmin, input int pmax,
                           input int start_at);
        int eref, esig, w0;
        build(g, pmin, pmax, eref, esig);
        do_start(g);
        chk({tag, "_busy_arm"}, 64'(busy), 64'd1);
        w0 = wr_cnt;
        if (start_at >= 0) gate_len = CNT_W'(5);
        run_wave(start_at);
        chk({tag, "_nwr"}, 64'(wr_cnt - w0), 64'd1);
        chk({tag, "_data"}, wr_last, {32'(esig), 32'(eref)});
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        int w0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        measure("p10", 100, 10, 10, -1);
        measure("p7", 100, 7, 7, -1);
        measure("gate0", 0, 10, 10, -1);

        do_start(100);
        w0 = wr_cnt;
        repeat (TO + 20) @(negedge clk);
        chk("to_nwr", 64'(wr_cnt - w0), 64'd1);
        chk("to_data", wr_last, 64'd0);
        chk("to_flag", 64'(timeout), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        measure("to_clear", 100, 10, 10, -1);

        measure("restart_ign", 100, 10, 10, 30);

        do_start(100);
        for (int c = 0; c < 40; c++) begin
            sig = ((c % 10) < 5);
            @(negedge clk);
        end
        chk("mid_busy", 64'(busy), 64'd1);
        w0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_wr_en", 64'(wr_en), 64'd0);
        chk("mid_rst_data", wr_data, 64'd0);
        chk("mid_rst_timeout", 64'(timeout), 64'd0);
        sig = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_nwr", 64'(wr_cnt - w0), 64'd0);
        measure("post_rst", 100, 10, 10, -1);

        for (int i = 0; i < 8; i++) begin
            measure($sformatf("rnd%0d", i), $urandom_range(150, 0), 2, 25, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
